// File: rtl/rfd_hs_rx.sv
// rfd_hs_rx: receive side of a toggle-handshake bus crossing.
// Detects a synchronized request toggle, waits SETTLE_CYCLES enabled cycles,
// captures the source-held word, offers it on a valid/ready port, and then
// answers with an acknowledge toggle.
// Optional feature macro: RFD_HSRX_PARITY_EN adds asyncParity and parityErr.
module rfd_hs_rx #(
   parameter int DATA_WIDTH    = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  outClk,
   input  logic                  outRst,
   input  logic                  outEn,
   input  logic                  reqSync,
   input  logic [DATA_WIDTH-1:0] asyncData,
`ifdef RFD_HSRX_PARITY_EN
   input  logic                  asyncParity,
`endif
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  dataValid,
   input  logic                  dataReady,
   output logic                  ackToggle,
   output logic                  busy,
   output logic [7:0]            overrunCnt
`ifdef RFD_HSRX_PARITY_EN
   ,
   output logic                  parityErr
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      OUT     = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   state_t                state;
   state_t                state_next;
   logic                  req_prev;
   logic                  req_prev_next;
   logic [3:0]            cnt;
   logic [3:0]            cnt_next;
   logic [DATA_WIDTH-1:0] data_next;
   logic                  valid_next;
   logic                  ack_next;
   logic [7:0]            overrun_next;
   logic                  req_event;

`ifdef RFD_HSRX_PARITY_EN
   logic                  parity_next;
`endif

   assign req_event = (reqSync != req_prev);
   assign busy      = (state != IDLE);

   // State register: reset wins over the enable, otherwise advance only on enabled edges.
   always_ff @(posedge outClk) begin
      if (outRst) begin
         state <= IDLE;
      end else if (outEn) begin
         state <= state_next;
      end
   end

   // Next-state and next-value logic for the handshake; overrun handling sits on top.
   always_comb begin
      state_next    = state;
      req_prev_next = req_prev;
      cnt_next      = cnt;
      data_next     = dataOut;
      valid_next    = dataValid;
      ack_next      = ackToggle;
      overrun_next  = overrunCnt;
`ifdef RFD_HSRX_PARITY_EN
      parity_next   = parityErr;
`endif

      case (state)
         IDLE: begin
            if (req_event) begin
               req_prev_next = reqSync;
               if (SETTLE_CYCLES > 0) begin
                  cnt_next   = SETTLE_LOAD;
                  state_next = SETTLE;
               end else begin
                  state_next = CAPTURE;
               end
            end
         end
         SETTLE: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            data_next  = asyncData;
            valid_next = 1'b1;
            state_next = OUT;
`ifdef RFD_HSRX_PARITY_EN
            if (^{asyncData, asyncParity}) begin
               parity_next = 1'b1;
            end
`endif
         end
         OUT: begin
            if (dataReady && dataValid) begin
               valid_next = 1'b0;
               ack_next   = ~ackToggle;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A toggle outside IDLE is dropped and counted; the current transfer is untouched.
      if (req_event && (state != IDLE)) begin
         req_prev_next = reqSync;
         if (overrunCnt != 8'd255) begin
            overrun_next = overrunCnt + 8'd1;
         end
      end
   end

   // Datapath and status registers, held while the enable is low.
   always_ff @(posedge outClk) begin
      if (outRst) begin
         req_prev   <= 1'b0;
         cnt        <= 4'd0;
         dataOut    <= '0;
         dataValid  <= 1'b0;
         ackToggle  <= 1'b0;
         overrunCnt <= 8'd0;
`ifdef RFD_HSRX_PARITY_EN
         parityErr  <= 1'b0;
`endif
      end else if (outEn) begin
         req_prev   <= req_prev_next;
         cnt        <= cnt_next;
         dataOut    <= data_next;
         dataValid  <= valid_next;
         ackToggle  <= ack_next;
         overrunCnt <= overrun_next;
`ifdef RFD_HSRX_PARITY_EN
         parityErr  <= parity_next;
`endif
      end
   end

endmodule

// File: doc/rfd_hs_rx.md
# rfd_hs_rx

Receive side of the toggle-handshake bus crossing. It sits directly downstream of the enable-gated two-flop synchronizer, which delivers the source domain's request toggle as `reqSync`. On each new request the block waits a programmable settle time, captures the source-held data bus, and presents the word on a valid/ready interface. It then returns an acknowledge toggle to the source domain, where it passes through that domain's own synchronizer.

## Interface
- `DATA_WIDTH`, 16: width of the crossed data word.
- `SETTLE_CYCLES`, 2: enabled cycles waited between request detection and capture; legal range 0..15.
- `outClk`  in  1  output-domain clock; all state changes on its rising edge.
- `outRst`  in  1  reset. **Synchronous, active-high, single clock `outClk`.**
- `outEn`  in  1  active-high clock enable. When low, every register holds, including the FSM, counters and outputs.
- `reqSync`  in  1  request toggle, already synchronized by the upstream synchronizer stage.
- `asyncData`  in  DATA_WIDTH  source-domain data. The source holds it stable from its request toggle until it sees the acknowledge.
- `asyncParity`  in  1  even parity over `asyncData`; present only with `RFD_HSRX_PARITY_EN`.
- `dataOut`  out  DATA_WIDTH  captured word; registered.
- `dataValid`  out  1  `dataOut` is valid; registered.
- `dataReady`  in  1  downstream accepts the word.
- `ackToggle`  out  1  acknowledge toggle to the source domain; registered.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `overrunCnt`  out  8  count of protocol violations; saturates at 255.
- `parityErr`  out  1  sticky parity error flag; present only with `RFD_HSRX_PARITY_EN`.

## Operation
- Internal register `reqPrev` holds the last request level consumed. A request event occurs when `reqSync != reqPrev`.
- The FSM has four states: IDLE, SETTLE, CAPTURE, OUT. The FSM advances only on edges where `outEn=1`.
  - IDLE: on an event, set `reqPrev<=reqSync`.
    - If `SETTLE_CYCLES>0`, load `cnt<=SETTLE_CYCLES` and go to SETTLE.
    - Otherwise go to CAPTURE.
  - SETTLE: decrement `cnt` each enabled edge. On the edge where `cnt==1`, go to CAPTURE.
  - CAPTURE: set `dataOut<=asyncData` and `dataValid<=1`, then go to OUT.
  - OUT: hold `dataValid` and `dataOut` until an enabled edge with `dataReady=1`. On that edge:
    - `dataValid<=0`
    - `ackToggle<=~ackToggle`
    - go to IDLE.
- Overrun: an event detected in any state other than IDLE is a protocol violation.
  - `overrunCnt` increments; at 255 it stays at 255.
  - `reqPrev<=reqSync`, so the extra toggle is consumed and dropped.
  - The transfer in progress continues unaffected.
- `busy = (state != IDLE)`; this is combinational from the state register.
- `dataReady` is ignored when `outEn=0` or `dataValid=0`.

## Timing
- Reset values: state=IDLE, `reqPrev=0`, `cnt=0`, `dataOut=0`, `dataValid=0`, `ackToggle=0`, `busy=0`, `overrunCnt=0`, `parityErr=0`.
- Reset takes priority over `outEn`.
- Let k be the enabled edge at which IDLE detects an event. `dataValid` rises after edge k+S+1, where S=`SETTLE_CYCLES`. With S=0 it rises after edge k+1.
- `ackToggle` flips on the accept edge. The earliest next detection is the following enabled edge.
- With `dataReady` tied high, a full transfer occupies S+3 enabled edges: detect, S settle edges, capture, accept.
- Disabled cycles (`outEn=0`) stretch all latencies one-for-one. SETTLE counts enabled edges only.
- Reset mid-transfer abandons the word and returns `ackToggle` to 0. The source domain shares this reset policy. If `reqSync=1` after reset, it is treated as a new request.
- An event arriving on the same edge as an accept in OUT counts as an overrun. The FSM still goes to IDLE.

## Configuration
- `RFD_HSRX_PARITY_EN` defined:
  - `asyncParity` and `parityErr` exist.
  - In CAPTURE, if `^{asyncData,asyncParity}` is 1, `parityErr<=1`.
  - `parityErr` is sticky and clears only on reset.
  - The word is still delivered.
- `RFD_HSRX_PARITY_EN` undefined: both ports are absent and no parity logic is built.

## Test plan
- S=2, `dataReady=1`, `outEn=1`. Toggle `reqSync` 0→1 with `asyncData=16'hA5C3` → `dataValid` high for one cycle after edge k+3 with `dataOut=16'hA5C3`. `ackToggle` goes to 1 on the same edge that `dataValid` falls. `busy` is high from k+1 through k+4.
- S=0, `dataReady=0` for 5 cycles then 1 → `dataValid` rises after edge k+1 and holds for 6 cycles with a stable `dataOut`. `ackToggle` flips once.
- Toggle `reqSync` twice while in OUT → `overrunCnt=2`, exactly one word delivered, one `ackToggle` flip. After 300 violations, `overrunCnt=255`.
- Drop `outEn` for 4 cycles during SETTLE (S=3) → `dataValid` rises 4 cycles later than with `outEn=1` throughout. No register changes while `outEn` is low.
- Assert `outRst` in OUT with `ackToggle=1` → next edge: `dataValid=0`, `ackToggle=0`, IDLE. With `reqSync` held at 1, a new transfer starts on the first edge after reset release.
- With `RFD_HSRX_PARITY_EN`: `asyncData=16'h0001`, `asyncParity=0` → `parityErr=1` after the capture edge. It stays 1 through later good words and clears only on `outRst`.
